busreq_sequencer: RTL and testbench
===================================

Name: busreq_sequencer

Overview:
- Control FSM for the 4-bit accumulator datapath.
- Per instruction it fetches an instruction byte, decodes it, and requests a register operand over the BUSREQ interface when needed.
- It then drives the external combinational ALU, latches the result into the accumulator and issues a write-back request.
- Sits between the top-level pin mux (ui_in / uo_out / uio_*) and the ALU.

Parameters:
- WAIT_MAX, 15, max cycles spent waiting for bus_ack/instr_valid in any wait state before timeout (1..255).
- DW, 4, accumulator/operand width (fixed at 4 for this tapeout; stated for clarity).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low = freeze all state (no transitions, counters hold)
- instr  in  8  instruction byte: [3:0] opcode, [7:4] immediate or register index
- instr_valid  in  1  instr is valid this cycle
- bus_data  in  4  register value returned by register block
- bus_ack  in  1  register block completed current request
- alu_result  in  4  combinational ALU output
- busreq  out  4  bus request code: 0000 idle, 0011 next operand/instruction, 0001 read register, 0010 write-back
- reg_idx  out  4  register index for read (0001) requests
- alu_a  out  4  ALU operand A (= acc)
- alu_b  out  4  ALU operand B (immediate or fetched register)
- alu_op  out  1  0 = add, 1 = subtract
- acc  out  4  accumulator; also write-back data
- busy  out  1  high in every state except IDLE/FETCH
- err  out  1  sticky timeout/illegal-opcode flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busreq=0000, reg_idx=0, alu_b=0, alu_op=0, acc=0, busy=0, err=0, timeout counter=0. Reset mid-operation aborts immediately; no write-back is issued.
- Opcodes:
  - 0000 NOP
  - 0001 ADDI: acc+=imm
  - 0010 SUBI: acc-=imm
  - 0011 ADDR: acc+=R[idx]
  - 0100 SUBR: acc-=R[idx]
  - all others illegal.
- Arithmetic is modulo 16; no carry/borrow retained.
- States and transitions (only when ena=1):
  - IDLE: one cycle after reset -> FETCH.
  - FETCH: busreq=0011. On instr_valid, latch instr -> DECODE.
  - DECODE:
    - NOP -> FETCH.
    - ADDI/SUBI: alu_b=imm, alu_op set -> EXEC.
    - ADDR/SUBR: reg_idx=instr[7:4] -> RDREG.
    - Illegal: set err -> FETCH.
  - RDREG: busreq=0001. On bus_ack, alu_b=bus_data -> EXEC.
  - EXEC: acc<=alu_result (single cycle, ALU is combinational on alu_a/alu_b/alu_op) -> WB.
  - WB: busreq=0010 with acc valid. On bus_ack -> FETCH.
- Latency: immediate op FETCH-accept to WB entry = 3 cycles; register op = 3 + ack wait.
- Timeout:
  - Counter clears on entering FETCH, RDREG or WB, and increments each enabled cycle while waiting.
  - Reaching WAIT_MAX in RDREG or WB sets err and -> FETCH; acc is unchanged in RDREG, already updated in WB.
  - In FETCH, waiting is unbounded (idle bus is legal).
- bus_ack is ignored outside RDREG/WB. instr_valid is ignored outside FETCH.
- Simultaneous instr_valid and bus_ack in FETCH: instr_valid wins.
- ena=0 freezes state, counter and all registered outputs. busreq holds its value.
- err clears only on reset.

Test Plan:
- Reset with acc=0; FETCH ADDI imm=2 (instr=0x21) -> busreq 0011, then 0010 with acc=2 within 3 cycles of accept; ack -> busreq 0011.
- After acc=2, ADDR idx=1 (instr=0x13); bench answers busreq 0001 with reg_idx=1, bus_data=4, ack -> write-back acc=6.
- acc=6, SUBI 7 (0x72) -> acc=15 (wrap); ADDI 3 (0x31) -> acc=2 (wrap).
- Illegal opcode 0x0F -> err=1, acc unchanged, returns to FETCH; err still 1 after next valid ADDI.
- RDREG with no bus_ack for WAIT_MAX=15 cycles -> err=1, back to FETCH, acc unchanged, busreq 0011.
- Drop ena during RDREG for 5 cycles -> state, busreq and counter frozen; assert rst_n=0 mid-WB -> all outputs zero asynchronously, no write-back completes.

Source files
------------

// File: rtl/busreq_sequencer.sv
// Control FSM for the 4-bit accumulator datapath. It fetches and decodes instructions,
// reads register operands over BUSREQ, drives the external ALU and issues the write-back.
module busreq_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int DW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [7:0]    instr,
    input  logic          instr_valid,
    input  logic [DW-1:0] bus_data,
    input  logic          bus_ack,
    input  logic [DW-1:0] alu_result,
    output logic [3:0]    busreq,
    output logic [3:0]    reg_idx,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_op,
    output logic [DW-1:0] acc,
    output logic          busy,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_RDREG, S_EXEC, S_WB
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUBI = 4'd2;
    localparam logic [3:0] OP_ADDR = 4'd3;
    localparam logic [3:0] OP_SUBR = 4'd4;

    localparam logic [3:0] BR_IDLE = 4'b0000;
    localparam logic [3:0] BR_NEXT = 4'b0011;
    localparam logic [3:0] BR_READ = 4'b0001;
    localparam logic [3:0] BR_WB   = 4'b0010;

    // A wait state gives up on the edge that would complete its WAIT_MAX-th waiting cycle.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e        state_q, state_d;
    logic [7:0]    instr_q, instr_d;
    logic [3:0]    reg_idx_q, reg_idx_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic          alu_op_q, alu_op_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          wait_expired;

    assign wait_expired = (cnt_q == WAIT_LAST);

    always_comb begin
        // NOTE: every *_d defaults to its flop so no branch can leave one unassigned (no latches).
        state_d   = state_q;
        instr_d   = instr_q;
        reg_idx_d = reg_idx_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        acc_d     = acc_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (instr_q[3:0])
                    OP_NOP: state_d = S_FETCH;
                    OP_ADDI, OP_SUBI: begin
                        alu_b_d  = instr_q[7:4];
                        alu_op_d = (instr_q[3:0] == OP_SUBI);
                        state_d  = S_EXEC;
                    end
                    OP_ADDR, OP_SUBR: begin
                        reg_idx_d = instr_q[7:4];
                        alu_op_d  = (instr_q[3:0] == OP_SUBR);
                        state_d   = S_RDREG;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_RDREG: begin
                if (bus_ack) begin
                    alu_b_d = bus_data;
                    state_d = S_EXEC;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                acc_d   = alu_result;
                state_d = S_WB;
            end
            S_WB: begin
                if (bus_ack) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Each wait state starts its budget from zero; FETCH never counts.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        busreq = BR_IDLE;
        case (state_q)
            S_FETCH: busreq = BR_NEXT;
            S_RDREG: busreq = BR_READ;
            S_WB:    busreq = BR_WB;
            default: busreq = BR_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_FETCH);
    assign reg_idx = reg_idx_q;
    assign alu_a   = acc_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;
    assign acc     = acc_q;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            reg_idx_q <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= 1'b0;
            acc_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else if (ena) begin
            // NOTE: non-blocking so every flop samples the pre-edge *_d values together.
            state_q   <= state_d;
            instr_q   <= instr_d;
            reg_idx_q <= reg_idx_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_busreq_sequencer.sv
// Randomized self-checking bench for busreq_sequencer: plays fetch source, register block
// and combinational ALU, and compares against an instruction-level accumulator model.
module tb_busreq_sequencer;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] instr;
    logic       instr_valid;
    logic [3:0] bus_data;
    logic       bus_ack;
    logic [3:0] alu_result;
    logic [3:0] busreq;
    logic [3:0] reg_idx;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_op;
    logic [3:0] acc;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [3:0] regs [16];
    logic [3:0] acc_m;
    logic       err_m;

    typedef struct packed {
        logic       back;
        logic       busy_bad;
        logic       saw_rd;
        logic [3:0] rd_idx;
        logic [7:0] rd_cycles;
        logic       saw_wb;
        logic [3:0] wb_acc;
        logic [7:0] wb_lat;
        logic [7:0] wb_cycles;
    } obs_t;

    typedef struct packed {
        logic [3:0] acc;
        logic       ill;
        logic       wb;
        logic       rd;
    } exp_t;

    busreq_sequencer #(.WAIT_MAX(WAIT_MAX), .DW(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .instr(instr), .instr_valid(instr_valid),
        .bus_data(bus_data), .bus_ack(bus_ack), .alu_result(alu_result),
        .busreq(busreq), .reg_idx(reg_idx), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .acc(acc), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // External combinational ALU.
    assign alu_result = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);

    // Instruction-level reference: what the accumulator becomes after one instruction.
    function automatic exp_t model(input logic [3:0] a, input logic [7:0] ins);
        exp_t e;
        int v, imm, r;
        v   = int'(a);
        imm = int'(ins[7:4]);
        r   = int'(regs[ins[7:4]]);
        e   = '0;
        case (ins[3:0])
            4'd0: ;
            4'd1: begin v = (v + imm) % 16;      e.wb = 1'b1; end
            4'd2: begin v = (v + 16 - imm) % 16; e.wb = 1'b1; end
            4'd3: begin v = (v + r) % 16;        e.wb = 1'b1; e.rd = 1'b1; end
            4'd4: begin v = (v + 16 - r) % 16;   e.wb = 1'b1; e.rd = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        e.acc = 4'(v);
        return e;
    endfunction

    // Feeds one instruction and services the bus until the FSM is back in FETCH.
    task automatic drive_instr(input logic [7:0] ins, input int rd_delay, input int wb_delay,
                               input bit noise, output obs_t o);
        int guard, lat, rd_n, wb_n;
        o = '0; guard = 0; rd_n = 0; wb_n = 0;
        while (busreq !== 4'b0011 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (busreq !== 4'b0011) return;
        instr = ins; instr_valid = 1'b1;
        bus_ack = noise ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0; bus_ack = 1'b0;
        lat = 1;
        while (lat < 100) begin
            if (busreq === 4'b0011) begin
                o.back = 1'b1;
                break;
            end
            if (busy !== 1'b1) o.busy_bad = 1'b1;
            instr       = 8'($urandom);
            instr_valid = noise ? 1'($urandom) : 1'b0;
            bus_data    = 4'($urandom);
            bus_ack     = 1'b0;
            case (busreq)
                4'b0001: begin
                    o.saw_rd = 1'b1;
                    o.rd_idx = reg_idx;
                    if (rd_n == rd_delay) begin
                        bus_data = regs[reg_idx];
                        bus_ack  = 1'b1;
                    end
                    rd_n++;
                end
                4'b0010: begin
                    if (!o.saw_wb) begin
                        o.saw_wb = 1'b1;
                        o.wb_acc = acc;
                        o.wb_lat = 8'(lat);
                    end
                    if (wb_n == wb_delay) bus_ack = 1'b1;
                    wb_n++;
                end
                default: bus_ack = noise ? 1'($urandom) : 1'b0;
            endcase
            @(posedge clk); #1;
            lat++;
        end
        o.rd_cycles = 8'(rd_n);
        o.wb_cycles = 8'(wb_n);
        instr_valid = 1'b0;
        bus_ack     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; instr_valid = 1'b0; bus_ack = 1'b0; ena = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        acc_m = 4'd0;
        err_m = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; instr = 8'h00; instr_valid = 1'b0;
        bus_data = 4'h0; bus_ack = 1'b0;
        #3;
        checks++;
        if ({busreq, reg_idx, alu_a, alu_b, alu_op, acc, busy, err} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busreq=%b reg_idx=%h alu_b=%h alu_op=%b acc=%h busy=%b err=%b, want all zero",
                     busreq, reg_idx, alu_b, alu_op, acc, busy, err);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        checks++;
        if (busreq !== 4'b0000) begin
            errors++; $display("FAIL reset_idle_busreq: got %b want 0000", busreq);
        end
        @(posedge clk); #1;
        checks++;
        if ({busreq, busy} !== {4'b0011, 1'b0}) begin
            errors++; $display("FAIL reset_to_fetch: got busreq=%b busy=%b want 0011/0", busreq, busy);
        end
        acc_m = 4'd0;
        err_m = 1'b0;
    endtask

    task automatic test_addi();
        obs_t o;
        drive_instr(8'h21, 0, 0, 1'b0, o);
        checks++;
        if ({o.back, o.saw_wb, o.wb_acc} !== {1'b1, 1'b1, 4'd2}) begin
            errors++; $display("FAIL addi_wb: got back=%b wb=%b wb_acc=%h want 1/1/2", o.back, o.saw_wb, o.wb_acc);
        end
        checks++;
        if (o.wb_lat !== 8'd3) begin
            errors++; $display("FAIL addi_latency: got %0d cycles want 3", o.wb_lat);
        end
        checks++;
        if ({acc, err, busreq, o.busy_bad} !== {4'd2, 1'b0, 4'b0011, 1'b0}) begin
            errors++; $display("FAIL addi_final: got acc=%h err=%b busreq=%b busy_bad=%b want 2/0/0011/0",
                               acc, err, busreq, o.busy_bad);
        end
        acc_m = 4'd2;
    endtask

    task automatic test_addr();
        obs_t o;
        regs[1] = 4'd4;
        drive_instr(8'h13, 2, 1, 1'b0, o);
        checks++;
        if ({o.saw_rd, o.rd_idx, o.rd_cycles} !== {1'b1, 4'd1, 8'd3}) begin
            errors++; $display("FAIL addr_read: got rd=%b idx=%h cycles=%0d want 1/1/3", o.saw_rd, o.rd_idx, o.rd_cycles);
        end
        checks++;
        if ({o.back, o.wb_acc, acc, o.wb_lat} !== {1'b1, 4'd6, 4'd6, 8'd6}) begin
            errors++; $display("FAIL addr_wb: got back=%b wb_acc=%h acc=%h lat=%0d want 1/6/6/6",
                               o.back, o.wb_acc, acc, o.wb_lat);
        end
        acc_m = 4'd6;
    endtask

    task automatic test_wrap();
        obs_t o;
        drive_instr(8'h72, 0, 1, 1'b0, o);
        checks++;
        if ({o.back, o.wb_acc, acc} !== {1'b1, 4'd15, 4'd15}) begin
            errors++; $display("FAIL subi_wrap: got back=%b wb_acc=%h acc=%h want 1/f/f", o.back, o.wb_acc, acc);
        end
        drive_instr(8'h31, 0, 0, 1'b0, o);
        checks++;
        if ({o.back, o.wb_acc, acc} !== {1'b1, 4'd2, 4'd2}) begin
            errors++; $display("FAIL addi_wrap: got back=%b wb_acc=%h acc=%h want 1/2/2", o.back, o.wb_acc, acc);
        end
        acc_m = 4'd2;
    endtask

    task automatic test_illegal();
        obs_t o;
        drive_instr(8'h0F, 0, 0, 1'b0, o);
        checks++;
        if ({o.back, o.saw_wb, o.saw_rd, acc, err} !== {1'b1, 1'b0, 1'b0, 4'd2, 1'b1}) begin
            errors++; $display("FAIL illegal_op: got back=%b wb=%b rd=%b acc=%h err=%b want 1/0/0/2/1",
                               o.back, o.saw_wb, o.saw_rd, acc, err);
        end
        drive_instr(8'h11, 0, 0, 1'b0, o);
        checks++;
        if ({o.wb_acc, acc, err} !== {4'd3, 4'd3, 1'b1}) begin
            errors++; $display("FAIL err_sticky: got wb_acc=%h acc=%h err=%b want 3/3/1", o.wb_acc, acc, err);
        end
        acc_m = 4'd3;
        err_m = 1'b1;
    endtask

    task automatic test_timeouts();
        obs_t o;
        do_reset();
        drive_instr(8'h51, 0, 0, 1'b0, o);
        drive_instr(8'h23, 1000, 0, 1'b0, o);
        checks++;
        if ({o.rd_cycles, o.saw_wb} !== {8'(WAIT_MAX), 1'b0}) begin
            errors++; $display("FAIL rdreg_timeout_len: got cycles=%0d wb=%b want %0d/0", o.rd_cycles, o.saw_wb, WAIT_MAX);
        end
        checks++;
        if ({o.back, acc, err, busreq} !== {1'b1, 4'd5, 1'b1, 4'b0011}) begin
            errors++; $display("FAIL rdreg_timeout_state: got back=%b acc=%h err=%b busreq=%b want 1/5/1/0011",
                               o.back, acc, err, busreq);
        end
        do_reset();
        drive_instr(8'h31, 0, 1000, 1'b0, o);
        checks++;
        if ({o.wb_cycles, o.wb_acc, acc, err, o.back} !== {8'(WAIT_MAX), 4'd3, 4'd3, 1'b1, 1'b1}) begin
            errors++; $display("FAIL wb_timeout: got cycles=%0d wb_acc=%h acc=%h err=%b back=%b want %0d/3/3/1/1",
                               o.wb_cycles, o.wb_acc, acc, err, o.back, WAIT_MAX);
        end
        acc_m = 4'd3;
        err_m = 1'b1;
    endtask

    task automatic test_ena_freeze();
        int n;
        do_reset();
        regs[6] = 4'd9;
        instr = 8'h63; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n = 0;
        while (busreq !== 4'b0001 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (busreq !== 4'b0001) begin
            errors++; $display("FAIL freeze_enter_rdreg: got busreq=%b want 0001", busreq);
        end
        repeat (3) @(posedge clk);
        #1;
        ena = 1'b0; bus_ack = 1'b1; instr_valid = 1'b1; instr = 8'h11; bus_data = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({busreq, reg_idx, acc, busy} !== {4'b0001, 4'd6, 4'd0, 1'b1}) begin
                errors++; $display("FAIL freeze_hold[%0d]: got busreq=%b idx=%h acc=%h busy=%b want 0001/6/0/1",
                                   i, busreq, reg_idx, acc, busy);
            end
        end
        ena = 1'b1; bus_ack = 1'b0; instr_valid = 1'b0;
        n = 0;
        while (busreq === 4'b0001 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n != WAIT_MAX - 3) begin
            errors++; $display("FAIL freeze_counter: got %0d remaining cycles want %0d", n, WAIT_MAX - 3);
        end
        checks++;
        if ({err, acc, busreq} !== {1'b1, 4'd0, 4'b0011}) begin
            errors++; $display("FAIL freeze_timeout: got err=%b acc=%h busreq=%b want 1/0/0011", err, acc, busreq);
        end
        acc_m = 4'd0;
        err_m = 1'b1;
    endtask

    task automatic test_reset_mid_wb();
        int n;
        instr = 8'h71; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n = 0;
        while (busreq !== 4'b0010 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if ({busreq, acc} !== {4'b0010, 4'd7}) begin
            errors++; $display("FAIL midwb_enter: got busreq=%b acc=%h want 0010/7", busreq, acc);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busreq, reg_idx, alu_a, alu_b, alu_op, acc, busy, err} !== 23'd0) begin
            errors++; $display("FAIL midwb_async_reset: got busreq=%b acc=%h alu_b=%h busy=%b err=%b want all zero",
                               busreq, acc, alu_b, busy, err);
        end
        bus_ack = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busreq, acc} !== {4'b0000, 4'd0}) begin
            errors++; $display("FAIL midwb_held: got busreq=%b acc=%h want 0000/0", busreq, acc);
        end
        #2 rst_n = 1'b1;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busreq, acc, err} !== {4'b0011, 4'd0, 1'b0}) begin
            errors++; $display("FAIL midwb_restart: got busreq=%b acc=%h err=%b want 0011/0/0", busreq, acc, err);
        end
        acc_m = 4'd0;
        err_m = 1'b0;
    endtask

    task automatic test_random();
        obs_t       o;
        exp_t       e;
        logic [7:0] ins;
        int         rd_d, wb_d, k;
        do_reset();
        for (int i = 0; i < 16; i++) regs[i] = 4'($urandom);
        for (int t = 0; t < 40; t++) begin
            k = int'($urandom_range(0, 5));
            ins[7:4] = 4'($urandom);
            ins[3:0] = (k == 5) ? 4'($urandom_range(5, 15)) : 4'(k);
            rd_d = int'($urandom_range(0, 4));
            wb_d = int'($urandom_range(0, 4));
            e = model(acc_m, ins);
            drive_instr(ins, rd_d, wb_d, 1'b1, o);
            checks++;
            if ({o.back, o.busy_bad, o.saw_wb, o.saw_rd} !== {1'b1, 1'b0, e.wb, e.rd}) begin
                errors++; $display("FAIL rand_flow[%0d] ins=%h: got back=%b busy_bad=%b wb=%b rd=%b want 1/0/%b/%b",
                                   t, ins, o.back, o.busy_bad, o.saw_wb, o.saw_rd, e.wb, e.rd);
            end
            checks++;
            if ({acc, err} !== {e.acc, err_m | e.ill}) begin
                errors++; $display("FAIL rand_acc[%0d] ins=%h: got acc=%h err=%b want %h/%b",
                                   t, ins, acc, err, e.acc, err_m | e.ill);
            end
            if (e.wb) begin
                checks++;
                if ({o.wb_acc, o.wb_cycles} !== {e.acc, 8'(wb_d + 1)}) begin
                    errors++; $display("FAIL rand_wb[%0d] ins=%h: got wb_acc=%h cycles=%0d want %h/%0d",
                                       t, ins, o.wb_acc, o.wb_cycles, e.acc, wb_d + 1);
                end
                checks++;
                if (o.wb_lat !== 8'(e.rd ? 4 + rd_d : 3)) begin
                    errors++; $display("FAIL rand_latency[%0d] ins=%h: got %0d want %0d",
                                       t, ins, o.wb_lat, e.rd ? 4 + rd_d : 3);
                end
            end
            if (e.rd) begin
                checks++;
                if ({o.rd_idx, o.rd_cycles} !== {ins[7:4], 8'(rd_d + 1)}) begin
                    errors++; $display("FAIL rand_read[%0d] ins=%h: got idx=%h cycles=%0d want %h/%0d",
                                       t, ins, o.rd_idx, o.rd_cycles, ins[7:4], rd_d + 1);
                end
            end
            acc_m = e.acc;
            err_m = err_m | e.ill;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 4'd0;
        test_reset();
        test_addi();
        test_addr();
        test_wrap();
        test_illegal();
        test_timeouts();
        test_ena_freeze();
        test_reset_mid_wb();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
